// File: rtl/demux_stream_1ton_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
//   route_e    : how an input beat is steered (unicast, broadcast or drop)
//   NUM_CH_MIN : smallest supported channel count
//   NUM_CH_MAX : largest supported channel count
//   ERR_W_DEF  : default width of the saturating drop counter
//   sel_w()    : select width needed to address n channels
package demux_stream_1ton_pkg;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;
  localparam int ERR_W_DEF  = 8;

  typedef enum logic [1:0] {
    ROUTE_UNI   = 2'd0,
    ROUTE_BCAST = 2'd1,
    ROUTE_DROP  = 2'd2
  } route_e;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_stream_1ton_slot.sv
// One-entry output register for a single demux channel.
//   clk_i   : rising-edge clock
//   rst_ni  : synchronous reset, active-low
//   load_i  : capture data_i and mark the slot valid
//   data_i  : payload to capture
//   ready_i : downstream consumer ready
//   valid_o : slot holds a beat
//   data_o  : held payload, stable while valid_o & ~ready_i
//   free_o  : slot can take a beat this cycle (empty, or draining now)
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    // A reload in the same cycle as a drain keeps the slot valid.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = ~valid_q | ready_i;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every channel.
// Each beat goes to channel in_sel_i, or to every channel when in_bcast_i=1.
// Unicast beats with an out-of-range select are accepted, dropped and
// counted in a saturating counter.
//   clk_i       : rising-edge clock
//   rst_ni      : synchronous reset, active-low
//   in_valid_i  : input beat valid
//   in_ready_o  : input beat accepted when in_valid_i & in_ready_o
//   in_data_i   : input payload
//   in_sel_i    : destination channel index
//   in_bcast_i  : deliver to all channels, in_sel_i ignored
//   out_valid_o : per-channel valid, bit k = channel k
//   out_ready_i : per-channel ready
//   out_data_o  : channel k payload at [k*DATA_W +: DATA_W]
//   err_cnt_o   : saturating count of dropped beats
module demux_stream_1ton
  import demux_stream_1ton_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = sel_w(NUM_CH),
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic [SEL_W-1:0]         in_sel_i,
  input  logic                     in_bcast_i,
  output logic [NUM_CH-1:0]        out_valid_o,
  input  logic [NUM_CH-1:0]        out_ready_i,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic [ERR_W-1:0]         err_cnt_o
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("demux_stream_1ton: NUM_CH must be in 2..16");
  end

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  route_e            route;
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic              sel_free;
  logic              rdy;
  logic              accept;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    if (in_bcast_i)                 route = ROUTE_BCAST;
    else if (int'(in_sel_i) < NUM_CH) route = ROUTE_UNI;
    else                            route = ROUTE_DROP;

    // Explicit loop keeps an out-of-range select from indexing past free.
    sel_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(in_sel_i) == k) sel_free = free[k];
    end

    // in_valid_i is deliberately absent so in_ready_o never depends on it.
    unique case (route)
      ROUTE_BCAST: rdy = &free;
      ROUTE_UNI:   rdy = sel_free;
      default:     rdy = 1'b1;
    endcase
    in_ready_o = rst_ni & rdy;
    accept     = in_valid_i & in_ready_o;

    load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept & ((route == ROUTE_BCAST) ||
                          ((route == ROUTE_UNI) && (int'(in_sel_i) == k)));
    end

    err_cnt_d = (accept && route == ROUTE_DROP) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;

  // Output register stage: one slot per channel.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[k]),
      .data_i  (in_data_i),
      .ready_i (out_ready_i[k]),
      .valid_o (out_valid_o[k]),
      .data_o  (out_data_o[k*DATA_W +: DATA_W]),
      .free_o  (free[k])
    );
  end

endmodule
